// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encodings, default widths and frame layout constants for the UART receive path
package uart_rx_pkg;

    localparam int PRE_W_DEF      = 6;
    localparam int ECNT_W_DEF     = 5;
    localparam int BCNT_W_DEF     = 4;
    localparam int DATA_BITS      = 8;
    localparam int STOP_IDX_NOPAR = 9;
    localparam int STOP_IDX_PAR   = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic int stop_idx(input logic par);
        return par ? STOP_IDX_PAR : STOP_IDX_NOPAR;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: sequencer <-> counter/sampler/checker signals; err_cnt exists only with UART_RX_ERR_CNT_EN
interface uart_rx_ctrl_if
    import uart_rx_pkg::*;
#(
    parameter int PRE_W  = PRE_W_DEF,
    parameter int ECNT_W = ECNT_W_DEF,
    parameter int BCNT_W = BCNT_W_DEF
);
    logic              RX_IN;
    logic              PAR_EN;
    logic [PRE_W-1:0]  Prescale;
    logic [ECNT_W-1:0] edge_cnt;
    logic [BCNT_W-1:0] bit_cnt;
    logic              strt_glitch;
    logic              par_err;
    logic              stp_err;
    logic              edge_cnt_en;
    logic              dat_samp_en;
    logic              strt_chk_en;
    logic              deser_en;
    logic              par_chk_en;
    logic              stp_chk_en;
    logic              data_valid;
    logic              frame_err;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    modport master (
        input  RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt, strt_glitch, par_err, stp_err,
        output edge_cnt_en, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
               data_valid, frame_err
`ifdef UART_RX_ERR_CNT_EN
               , err_cnt
`endif
    );

    modport slave (
        output RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt, strt_glitch, par_err, stp_err,
        input  edge_cnt_en, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
               data_valid, frame_err
`ifdef UART_RX_ERR_CNT_EN
               , err_cnt
`endif
    );

endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer (start/data/parity/stop strobes, frame result pulses); UART_RX_ERR_CNT_EN adds a saturating frame error counter
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRE_W  = PRE_W_DEF,
    parameter int ECNT_W = ECNT_W_DEF,
    parameter int BCNT_W = BCNT_W_DEF
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_ctrl_if.master bus
);

    state_t            state, state_nx;
    logic              par_en_q, err_flag, dv_q, fe_q;
    logic [ECNT_W-1:0] cp, last;
    logic              at_cp, at_last, stp_hit, bad;

    assign cp      = ECNT_W'(bus.Prescale >> 1) + ECNT_W'(1);
    assign last    = ECNT_W'(bus.Prescale - PRE_W'(1));
    assign at_cp   = bus.edge_cnt == cp;
    assign at_last = bus.edge_cnt == last;
    assign stp_hit = state == STOP && at_cp && bus.bit_cnt == BCNT_W'(stop_idx(par_en_q));
    assign bad     = err_flag | bus.stp_err;

    assign bus.edge_cnt_en = state != IDLE;
    assign bus.dat_samp_en = state != IDLE;
    assign bus.strt_chk_en = state == START && at_cp;
    assign bus.deser_en    = state == DATA && at_cp;
    assign bus.par_chk_en  = state == PARITY && at_cp;
    assign bus.stp_chk_en  = stp_hit;
    assign bus.data_valid  = dv_q;
    assign bus.frame_err   = fe_q;

    // next state: walk the frame on counter milestones; stop releases the counter right after its check
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.RX_IN ? IDLE : START;
            START:   state_nx = (at_cp && bus.strt_glitch) ? IDLE : (at_last ? DATA : START);
            DATA:    state_nx = (at_last && bus.bit_cnt == BCNT_W'(DATA_BITS)) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  state_nx = at_last ? STOP : PARITY;
            STOP:    state_nx = stp_hit ? IDLE : STOP;
            default: state_nx = IDLE;
        endcase
    end

    // state, latched frame options, accumulated parity error and registered result pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            par_en_q <= 1'b0;
            err_flag <= 1'b0;
            dv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && !bus.RX_IN) begin
                par_en_q <= bus.PAR_EN;
                err_flag <= 1'b0;
            end else if (state == PARITY && at_cp) begin
                err_flag <= err_flag | bus.par_err;
            end
            dv_q <= stp_hit && !bad;
            fe_q <= stp_hit && bad;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    assign bus.err_cnt = err_cnt_q;

    // count frame_err pulses, holding at 255
    always_ff @(posedge CLK) begin
        if (RST) err_cnt_q <= 8'd0;
        else if (fe_q && err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
    end
`endif

endmodule
